// File: rtl/sao_stat_ctb_accum_if.sv
// Beat-input and result-handshake bundle for sao_stat_ctb_accum.
// The master side feeds beats and consumes results; the slave side is the accumulator.
interface sao_stat_ctb_accum_if #(
    parameter int diff_clip_bit = 4,
    parameter int SUM_BW        = 18,
    parameter int CNT_BW        = 13
);
    logic                          ctb_start;
    logic                          in_valid;
    logic signed [diff_clip_bit+1:0] s21;
    logic [1:0]                    n21;
    logic                          ctb_last;
    logic                          out_ready;
    logic                          out_valid;
    logic signed [SUM_BW-1:0]      sum_out;
    logic [CNT_BW-1:0]             cnt_out;

    modport master (
        output ctb_start, in_valid, s21, n21, ctb_last, out_ready,
        input  out_valid, sum_out, cnt_out
    );

    modport slave (
        input  ctb_start, in_valid, s21, n21, ctb_last, out_ready,
        output out_valid, sum_out, cnt_out
    );
endinterface

// File: rtl/sao_stat_ctb_accum.sv
// Per-lane CTB accumulator of SAO diff sums and matching-pixel counts.
// Optional macro SAO_STAT_SAT_EN: saturating sum instead of wrap-around.
module sao_stat_ctb_accum #(
    parameter int diff_clip_bit = 4,
    parameter int SUM_BW        = 18,
    parameter int CNT_BW        = 13
) (
    input  logic                 clk,
    input  logic                 arst_n,
    sao_stat_ctb_accum_if.slave  bus,
    output logic                 busy
);
    localparam int S21_BW = diff_clip_bit + 2;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                   state;
    logic signed [SUM_BW-1:0] sum;
    logic [CNT_BW-1:0]        cnt;
    logic                     out_valid;

    logic signed [S21_BW-1:0] s21;
    logic signed [SUM_BW-1:0] s21_ext;
    logic signed [SUM_BW-1:0] sum_beat;
    logic [CNT_BW-1:0]        cnt_beat;
    logic [CNT_BW-1:0]        cnt_first;

    function automatic logic signed [SUM_BW-1:0] sum_add(
        input logic signed [SUM_BW-1:0] a,
        input logic signed [SUM_BW-1:0] b
    );
        logic signed [SUM_BW-1:0] raw;
        raw = a + b;
`ifdef SAO_STAT_SAT_EN
        // Same-sign operands producing an opposite-sign result means overflow.
        if ((a[SUM_BW-1] == b[SUM_BW-1]) && (raw[SUM_BW-1] != a[SUM_BW-1]))
            raw = a[SUM_BW-1] ? {1'b1, {(SUM_BW-1){1'b0}}} : {1'b0, {(SUM_BW-1){1'b1}}};
`endif
        return raw;
    endfunction

    function automatic logic [CNT_BW-1:0] cnt_add(
        input logic [CNT_BW-1:0] a,
        input logic [1:0]        n
    );
        logic [CNT_BW:0] wide;
        wide = {1'b0, a} + (CNT_BW+1)'(n);
        return wide[CNT_BW] ? {CNT_BW{1'b1}} : wide[CNT_BW-1:0];
    endfunction

    assign s21       = bus.s21;
    assign s21_ext   = SUM_BW'(s21);
    assign sum_beat  = sum_add(sum, s21_ext);
    assign cnt_beat  = cnt_add(cnt, bus.n21);
    assign cnt_first = cnt_add('0, bus.n21);

    assign bus.out_valid = out_valid;
    assign bus.sum_out   = sum;
    assign bus.cnt_out   = cnt;

    // A start in IDLE may carry the first (or only) beat of the CTB.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            sum       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ctb_start) begin
                        busy <= 1'b1;
                        sum  <= bus.in_valid ? s21_ext : '0;
                        cnt  <= bus.in_valid ? cnt_first : '0;
                        if (bus.in_valid && bus.ctb_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        sum <= sum_beat;
                        cnt <= cnt_beat;
                        if (bus.ctb_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (bus.ctb_start) begin
                            state <= ACC;
                            sum   <= '0;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sao_stat_ctb_accum.sv
// Bench for sao_stat_ctb_accum: a wide and a narrow instance share one stimulus
// stream and are compared each cycle against an unbounded-integer model.
module tb_sao_stat_ctb_accum;
    localparam int DCB   = 4;
    localparam int S_BW  = DCB + 2;
    localparam int BIG_S = 18;
    localparam int BIG_C = 13;
    localparam int SML_S = 6;
    localparam int SML_C = 3;

    logic clk = 1'b0;
    logic arst_n;
    logic ctb_start, in_valid, ctb_last, out_ready;
    logic signed [S_BW-1:0] s21;
    logic [1:0] n21;
    logic busy_big, busy_sml;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: outcome of the CTB as exact integers, narrowed per instance on compare.
    bit     m_coll  = 1'b0;
    bit     m_ready = 1'b0;
    longint m_sum_full = 0;
    longint m_cnt_full = 0;
    longint m_sum_sat [2] = '{0, 0};
    int     sbw [2] = '{BIG_S, SML_S};
    int     cbw [2] = '{BIG_C, SML_C};

    sao_stat_ctb_accum_if #(.diff_clip_bit(DCB), .SUM_BW(BIG_S), .CNT_BW(BIG_C)) if_big ();
    sao_stat_ctb_accum_if #(.diff_clip_bit(DCB), .SUM_BW(SML_S), .CNT_BW(SML_C)) if_sml ();

    assign if_big.ctb_start = ctb_start;
    assign if_big.in_valid  = in_valid;
    assign if_big.s21       = s21;
    assign if_big.n21       = n21;
    assign if_big.ctb_last  = ctb_last;
    assign if_big.out_ready = out_ready;
    assign if_sml.ctb_start = ctb_start;
    assign if_sml.in_valid  = in_valid;
    assign if_sml.s21       = s21;
    assign if_sml.n21       = n21;
    assign if_sml.ctb_last  = ctb_last;
    assign if_sml.out_ready = out_ready;

    sao_stat_ctb_accum #(.diff_clip_bit(DCB), .SUM_BW(BIG_S), .CNT_BW(BIG_C)) u_big (
        .clk(clk), .arst_n(arst_n), .bus(if_big), .busy(busy_big));
    sao_stat_ctb_accum #(.diff_clip_bit(DCB), .SUM_BW(SML_S), .CNT_BW(SML_C)) u_sml (
        .clk(clk), .arst_n(arst_n), .bus(if_sml), .busy(busy_sml));

    always #5 clk = ~clk;

    function automatic longint wrap_signed(input longint v, input int w);
        longint m, r;
        m = longint'(1) << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic longint clamp_signed(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint exp_sum(input int i);
`ifdef SAO_STAT_SAT_EN
        return m_sum_sat[i];
`else
        return wrap_signed(m_sum_full, sbw[i]);
`endif
    endfunction

    function automatic longint exp_cnt(input int i);
        longint cap;
        cap = (longint'(1) << cbw[i]) - 1;
        return (m_cnt_full > cap) ? cap : m_cnt_full;
    endfunction

    function automatic void model_clear();
        m_sum_full = 0;
        m_cnt_full = 0;
        m_sum_sat[0] = 0;
        m_sum_sat[1] = 0;
    endfunction

    function automatic void model_beat(input longint s, input longint n);
        m_sum_full += s;
        m_cnt_full += n;
        for (int i = 0; i < 2; i++) m_sum_sat[i] = clamp_signed(m_sum_sat[i] + s, sbw[i]);
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_coll  = 1'b0;
            m_ready = 1'b0;
            model_clear();
        end else if (m_ready) begin
            if (out_ready) begin
                m_ready = 1'b0;
                if (ctb_start) begin
                    model_clear();
                    m_coll = 1'b1;
                end
            end
        end else if (m_coll || ctb_start) begin
            if (!m_coll) model_clear();
            m_coll = 1'b1;
            if (in_valid) begin
                model_beat(longint'(s21), longint'(n21));
                if (ctb_last) begin
                    m_coll  = 1'b0;
                    m_ready = 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("big.out_valid", longint'(if_big.out_valid), longint'(m_ready));
            check_output("big.busy", longint'(busy_big), longint'(m_coll || m_ready));
            check_output("big.sum_out", longint'(if_big.sum_out), exp_sum(0));
            check_output("big.cnt_out", longint'(if_big.cnt_out), exp_cnt(0));
            check_output("sml.out_valid", longint'(if_sml.out_valid), longint'(m_ready));
            check_output("sml.busy", longint'(busy_sml), longint'(m_coll || m_ready));
            check_output("sml.sum_out", longint'(if_sml.sum_out), exp_sum(1));
            check_output("sml.cnt_out", longint'(if_sml.cnt_out), exp_cnt(1));
        end
    end

    task automatic apply_stimulus(input logic st, input logic v, input int s,
                                  input logic [1:0] n, input logic l, input logic r);
        ctb_start = st;
        in_valid  = v;
        s21       = S_BW'(s);
        n21       = n;
        ctb_last  = l;
        out_ready = r;
        @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("reset.out_valid", longint'(if_big.out_valid), 0);
        check_output("reset.sum_out", longint'(if_big.sum_out), 0);
        check_output("reset.cnt_out", longint'(if_big.cnt_out), 0);
        check_output("reset.busy", longint'(busy_big), 0);
        arst_n = 1'b1;
        chk_en = 1'b1;

        // Basic CTB: +3-5+7 over 2+1+2 pixels.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 3, 2, 0, 0);
        apply_stimulus(0, 1, -5, 1, 0, 0);
        check_output("basic.pre_valid", longint'(if_big.out_valid), 0);
        apply_stimulus(0, 1, 7, 2, 1, 0);
        check_output("basic.out_valid", longint'(if_big.out_valid), 1);
        check_output("basic.sum_out", longint'(if_big.sum_out), 5);
        check_output("basic.cnt_out", longint'(if_big.cnt_out), 5);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        check_output("basic.idle_busy", longint'(busy_big), 0);

        // Start, beat and last in one IDLE cycle.
        apply_stimulus(1, 1, -4, 2, 1, 0);
        check_output("oneshot.out_valid", longint'(if_big.out_valid), 1);
        check_output("oneshot.sum_out", longint'(if_big.sum_out), -4);
        check_output("oneshot.cnt_out", longint'(if_big.cnt_out), 2);

        // Backpressure with ignored beats and an ignored start.
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(k == 2, 1, 9, 2, k[0], 0);
            check_output("hold.sum_out", longint'(if_big.sum_out), -4);
            check_output("hold.cnt_out", longint'(if_big.cnt_out), 2);
        end
        apply_stimulus(1, 0, 0, 0, 0, 1);
        check_output("b2b.out_valid", longint'(if_big.out_valid), 0);
        check_output("b2b.busy", longint'(busy_big), 1);
        check_output("b2b.sum_out", longint'(if_big.sum_out), 0);
        check_output("b2b.cnt_out", longint'(if_big.cnt_out), 0);

        // Asynchronous reset mid-CTB.
        for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 3, 1, 0, 0);
        check_output("midrst.pre_sum", longint'(if_big.sum_out), 9);
        #2 arst_n = 1'b0;
        #1;
        check_output("midrst.sum_out", longint'(if_big.sum_out), 0);
        check_output("midrst.cnt_out", longint'(if_big.cnt_out), 0);
        check_output("midrst.busy", longint'(busy_big), 0);
        @(negedge clk);
        arst_n = 1'b1;
        apply_stimulus(0, 1, 5, 1, 0, 0);
        apply_stimulus(0, 1, 5, 1, 1, 0);
        check_output("midrst.ignored_sum", longint'(if_big.sum_out), 0);
        check_output("midrst.ignored_valid", longint'(if_big.out_valid), 0);

        // Sum overflow on the narrow lane, count saturation, start ignored in ACC.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 15, 2, 0, 0);
`ifdef SAO_STAT_SAT_EN
        check_output("ovf.sml_sum", longint'(if_sml.sum_out), 31);
`else
        check_output("ovf.sml_sum", longint'(if_sml.sum_out), -19);
`endif
        check_output("ovf.big_sum", longint'(if_big.sum_out), 45);
        apply_stimulus(1, 1, 0, 2, 0, 0);
        apply_stimulus(0, 1, 0, 2, 1, 0);
        check_output("cntsat.sml_cnt", longint'(if_sml.cnt_out), 7);
        check_output("cntsat.big_cnt", longint'(if_big.cnt_out), 10);
        check_output("cntsat.big_sum", longint'(if_big.sum_out), 45);
        apply_stimulus(0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            apply_stimulus($urandom_range(0, 5) == 0,
                           $urandom_range(0, 9) < 7,
                           int'($urandom_range(0, 63)) - 32,
                           2'($urandom_range(0, 2)),
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 9) < 6);
        end
        apply_stimulus(0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
